// File: rtl/dmem_bus_pkg.sv
// Shared definitions for the data-memory read bus: state encoding and default widths.
package dmem_bus_pkg;

    localparam int DEFAULT_ADDR_W         = 32;
    localparam int DEFAULT_DATA_W         = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;
    localparam int DEFAULT_CNT_W          = 7;

    typedef enum logic [1:0] {
        ST_IDLE            = 2'b00,
        ST_WAIT_READY_HIGH = 2'b01,
        ST_WAIT_READY_LOW  = 2'b10
    } dmem_state_e;

endpackage

// File: rtl/dmem_timeout_counter.sv
// Per-phase wait counter: cleared on phase change, flags the last allowed cycle.
module dmem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LP_LAST);

endmodule

// File: rtl/dmem_read_initiator.sv
// Read initiator driving the four-phase Read/Ready handshake toward data memory,
// returning captured data or a timeout error to the requester.
module dmem_read_initiator
    import dmem_bus_pkg::*;
#(
    parameter int ADDR_W         = DEFAULT_ADDR_W,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    // Request handshake: a request transfers on a rising edge where req_valid
    // and req_ready are both 1; req_addr must be stable while req_valid is high.
    // rsp_valid is a one-cycle pulse with no backpressure.
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_error,
    output logic              Bus_DataMem_Read,
    output logic [ADDR_W-1:0] Bus_DataMem_Address,
    input  logic              Bus_DataMem_Ready,
    input  logic [DATA_W-1:0] Bus_DataMem_In,
    output logic [1:0]        dbg_state
);

    dmem_state_e       r_state;
    dmem_state_e       w_state_nxt;
    logic              w_accept;
    logic              w_capture;
    logic              w_timeout;
    logic              w_cnt_enable;
    logic              w_cnt_clear;
    logic              w_expired;
    logic              w_req_ready;
    logic              r_read;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_error;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_cnt_enable = 1'b0;
        w_req_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_WAIT_READY_HIGH;
                end
            end
            ST_WAIT_READY_HIGH: begin
                w_cnt_enable = 1'b1;
                // Ready takes priority over an expiring counter on the same edge.
                if (Bus_DataMem_Ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_WAIT_READY_LOW;
                end else if (w_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_WAIT_READY_LOW;
                end
            end
            ST_WAIT_READY_LOW: begin
                w_cnt_enable = 1'b1;
                if (!Bus_DataMem_Ready || w_expired) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_cnt_clear = (w_state_nxt != r_state) || !w_cnt_enable;

    dmem_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_cnt_clear),
        .i_enable  (w_cnt_enable),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_read      <= 1'b0;
            r_addr      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            r_read      <= (w_state_nxt == ST_WAIT_READY_HIGH);
            r_rsp_valid <= w_capture || w_timeout;
            if (w_accept) begin
                r_addr <= req_addr;
            end
            if (w_capture) begin
                r_rsp_data  <= Bus_DataMem_In;
                r_rsp_error <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_data  <= '0;
                r_rsp_error <= 1'b1;
            end
        end
    end

    assign req_ready           = w_req_ready;
    assign rsp_valid           = r_rsp_valid;
    assign rsp_data            = r_rsp_data;
    assign rsp_error           = r_rsp_error;
    assign Bus_DataMem_Read    = r_read;
    assign Bus_DataMem_Address = r_addr;
    assign dbg_state           = r_state;

endmodule

// File: tb/tb_dmem_read_initiator.sv
// Directed bench for dmem_read_initiator with a memory responder and a
// transaction-level reference model compared on every falling edge.
module tb_dmem_read_initiator;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_error;
    logic          bus_read;
    logic [AW-1:0] bus_addr;
    logic          bus_ready;
    logic [DW-1:0] bus_in;
    logic [1:0]    dbg_state;

    int n_vec = 0;
    int n_err = 0;

    // responder configuration: delay 0 means Ready never rises
    int            resp_delay = 2;
    int            resp_hold  = 0;
    bit            resp_fixed = 1'b0;
    logic [DW-1:0] fixed_data = '0;
    int            rcnt = 0;
    int            hold_left = 0;

    // response log for back-to-back ordering
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    int            got_t[$];
    int            cyc = 0;

    dmem_read_initiator #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (CW)
    ) dut (
        .clk                 (clk),
        .reset               (rst_n),
        .req_valid           (req_valid),
        .req_addr            (req_addr),
        .req_ready           (req_ready),
        .rsp_valid           (rsp_valid),
        .rsp_data            (rsp_data),
        .rsp_error           (rsp_error),
        .Bus_DataMem_Read    (bus_read),
        .Bus_DataMem_Address (bus_addr),
        .Bus_DataMem_Ready   (bus_ready),
        .Bus_DataMem_In      (bus_in),
        .dbg_state           (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the transaction by elapsed cycles in each bus phase.
    bit            m_busy, m_rel, m_read, m_rv, m_re;
    int            m_k;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_rel <= 1'b0; m_k <= 0; m_read <= 1'b0;
            m_addr <= '0; m_rv <= 1'b0; m_rd <= '0; m_re <= 1'b0;
        end else begin
            m_rv <= 1'b0;
            if (m_busy) begin
                if (bus_ready) begin
                    m_rd <= bus_in; m_re <= 1'b0; m_rv <= 1'b1;
                    m_read <= 1'b0; m_busy <= 1'b0; m_rel <= 1'b1; m_k <= 0;
                end else if (m_k + 1 == T) begin
                    m_rd <= '0; m_re <= 1'b1; m_rv <= 1'b1;
                    m_read <= 1'b0; m_busy <= 1'b0; m_rel <= 1'b1; m_k <= 0;
                end else begin
                    m_k <= m_k + 1;
                end
            end else if (m_rel) begin
                if (!bus_ready || m_k + 1 == T) begin
                    m_rel <= 1'b0; m_k <= 0;
                end else begin
                    m_k <= m_k + 1;
                end
            end else if (req_valid) begin
                m_addr <= req_addr; m_read <= 1'b1; m_busy <= 1'b1; m_k <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("read",      {63'd0, bus_read},  {63'd0, m_read});
            chk("address",   {32'd0, bus_addr},  {32'd0, m_addr});
            chk("req_ready", {63'd0, req_ready}, {63'd0, !(m_busy || m_rel)});
            chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_rv});
            chk("rsp_data",  {32'd0, rsp_data},  {32'd0, m_rd});
            chk("rsp_error", {63'd0, rsp_error}, {63'd0, m_re});
        end
    end

    // ---------------- memory responder ----------------
    initial begin
        bus_ready = 1'b0;
        bus_in    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rcnt = 0;
                bus_ready = 1'b0;
            end else if (bus_read) begin
                rcnt++;
                if (resp_delay != 0 && rcnt >= resp_delay && !bus_ready) begin
                    bus_ready = 1'b1;
                    bus_in    = resp_fixed ? fixed_data : bus_addr + 32'd6;
                    hold_left = resp_hold;
                end else if (!bus_ready) begin
                    bus_in = $urandom;
                end
            end else begin
                rcnt = 0;
                if (bus_ready && hold_left > 0) begin
                    hold_left--;
                end else begin
                    bus_ready = 1'b0;
                    bus_in    = $urandom;
                end
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && rsp_valid) begin
                got_q.push_back(rsp_data);
                got_t.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send(input logic [AW-1:0] addr, output int waited);
        req_valid = 1'b1;
        req_addr  = addr;
        waited    = 0;
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_seen", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
    endtask

    task automatic wait_rsp(output int n, output logic [DW-1:0] data, output logic err);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_seen", {63'd0, rsp_valid}, 64'd1);
        data = rsp_data;
        err  = rsp_error;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int            w;
        int            n;
        logic [DW-1:0] d;
        logic          e;

        repeat (3) @(negedge clk);
        chk("rst_read",      {63'd0, bus_read},  64'd0);
        chk("rst_address",   {32'd0, bus_addr},  64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_data",  {32'd0, rsp_data},  64'd0);
        chk("rst_rsp_error", {63'd0, rsp_error}, 64'd0);
        chk("rst_state",     {62'd0, dbg_state}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // basic read, Ready two cycles after Read rises
        resp_delay = 2; resp_hold = 0;
        send(32'h100, w);
        chk("t1_read_rise", {63'd0, bus_read}, 64'd1);
        chk("t1_addr", {32'd0, bus_addr}, 64'h100);
        wait_rsp(n, d, e);
        chk("t1_latency", n, 2);
        chk("t1_data", {32'd0, d}, 64'h106);
        chk("t1_error", {63'd0, e}, 64'd0);
        chk("t1_read_low", {63'd0, bus_read}, 64'd0);
        chk("t1_busy", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        chk("t1_ready_back", {63'd0, req_ready}, 64'd1);

        // Ready held 4 cycles after Read drops; pending request must wait
        resp_hold = 4;
        send(32'h180, w);
        wait_rsp(n, d, e);
        chk("t2_first_data", {32'd0, d}, 64'h186);
        resp_hold = 0;
        send(32'h200, w);
        chk("t2_accept_wait", w, 5);
        wait_rsp(n, d, e);
        chk("t2_data", {32'd0, d}, 64'h206);
        chk("t2_error", {63'd0, e}, 64'd0);

        // Ready never rises: timeout after T cycles with Read high
        resp_delay = 0;
        send(32'h300, w);
        wait_rsp(n, d, e);
        chk("t3_latency", n, T);
        chk("t3_data", {32'd0, d}, 64'd0);
        chk("t3_error", {63'd0, e}, 64'd1);
        chk("t3_read_low", {63'd0, bus_read}, 64'd0);

        // Ready rises exactly on the timeout edge: capture wins
        resp_delay = T; resp_fixed = 1'b1; fixed_data = 32'hDEAD;
        send(32'h400, w);
        wait_rsp(n, d, e);
        chk("t4_latency", n, T);
        chk("t4_data", {32'd0, d}, 64'hDEAD);
        chk("t4_error", {63'd0, e}, 64'd0);
        resp_fixed = 1'b0;

        // reset mid-transaction drops Read without waiting for a clock edge
        resp_delay = 0;
        send(32'h500, w);
        @(negedge clk);
        chk("t5_read_before", {63'd0, bus_read}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_read_async", {63'd0, bus_read}, 64'd0);
        chk("t5_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("t5_req_ready", {63'd0, req_ready}, 64'd1);
        chk("t5_address", {32'd0, bus_addr}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        resp_delay = 2;
        send(32'h10, w);
        chk("t5_accept_wait", w, 0);
        wait_rsp(n, d, e);
        chk("t5_data", {32'd0, d}, 64'h16);
        chk("t5_error", {63'd0, e}, 64'd0);
        repeat (3) @(negedge clk);

        // back-to-back requests with an immediate responder
        resp_delay = 1;
        got_q.delete();
        got_t.delete();
        exp_q.push_back(32'h6);
        exp_q.push_back(32'hA);
        exp_q.push_back(32'hE);
        send(32'h0, w);
        send(32'h4, w);
        send(32'h8, w);
        n = 0;
        while (got_q.size() < 3 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("t6_count", got_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (got_q.size() > 0 && exp_q.size() > 0) begin
                chk("t6_data", {32'd0, got_q.pop_front()}, {32'd0, exp_q.pop_front()});
            end
        end
        if (got_t.size() == 3) begin
            chk("t6_spacing_a", got_t[1] - got_t[0], 3);
            chk("t6_spacing_b", got_t[2] - got_t[1], 3);
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
